// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: command codes, FSM states and
// the per-command slice control decode.
package alu_pkg;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    typedef enum logic [1:0] {F_SUM, F_XOR, F_NAND, F_NOR} fsel_t;

    typedef struct packed {
        logic  invta;
        logic  invtb;
        logic  cin0;
        fsel_t fsel;
        logic  is_arith;
    } ctrl_t;

    // AND and OR reuse the nor/nand gates on inverted operands (De Morgan).
    function automatic ctrl_t decode(input logic [2:0] cmd);
        ctrl_t c;
        c.invta    = 1'b0;
        c.invtb    = 1'b0;
        c.cin0     = 1'b0;
        c.fsel     = F_SUM;
        c.is_arith = 1'b0;
        case (cmd)
            CMD_ADD:  c.is_arith = 1'b1;
            CMD_SUB: begin
                c.invtb    = 1'b1;
                c.cin0     = 1'b1;
                c.is_arith = 1'b1;
            end
            CMD_SLT: begin
                c.invtb = 1'b1;
                c.cin0  = 1'b1;
            end
            CMD_XOR:  c.fsel = F_XOR;
            CMD_AND: begin
                c.invta = 1'b1;
                c.invtb = 1'b1;
                c.fsel  = F_NOR;
            end
            CMD_NAND: c.fsel = F_NAND;
            CMD_NOR:  c.fsel = F_NOR;
            CMD_OR: begin
                c.invta = 1'b1;
                c.invtb = 1'b1;
                c.fsel  = F_NAND;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_serial_bit.sv
// Combinational 1-bit ALU slice: full adder plus xor/nand/nor gates,
// with optional operand inversion feeding everything except xor.
module alu_serial_bit
    import alu_pkg::*;
(
    input  logic  a,
    input  logic  b,
    input  logic  cin,
    input  logic  invta,
    input  logic  invtb,
    input  fsel_t fsel,
    output logic  result,
    output logic  cout,
    output logic  sum
);

    logic aa;
    logic bb;

    assign aa   = a ^ invta;
    assign bb   = b ^ invtb;
    assign sum  = aa ^ bb ^ cin;
    assign cout = (aa & bb) | (aa & cin) | (bb & cin);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        result = sum;
        case (fsel)
            F_SUM:   result = sum;
            F_XOR:   result = a ^ b;
            F_NAND:  result = ~(aa & bb);
            F_NOR:   result = ~(aa | bb);
            default: result = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: latches an operand pair, runs one bit per clock LSB first
// through a single slice, then registers result and flags on the FIN edge.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             fin;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       cmd_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] shreg;
    logic             carry_q;
    logic             ovf_q;
    logic             sign_q;

    logic [2:0]       cmd_cur;
    ctrl_t            ctrl;
    logic             bit_res;
    logic             bit_cout;
    logic             bit_sum;
    logic [WIDTH-1:0] res_final;

    // In IDLE the decode looks at the incoming command so cin0 can seed the
    // carry flop on the load edge; otherwise it follows the latched command.
    assign cmd_cur = (state == IDLE) ? command : cmd_q;
    assign ctrl    = decode(cmd_cur);

    alu_serial_bit u_bit (
        .a      (a_q[count_q]),
        .b      (b_q[count_q]),
        .cin    (carry_q),
        .invta  (ctrl.invta),
        .invtb  (ctrl.invtb),
        .fsel   (ctrl.fsel),
        .result (bit_res),
        .cout   (bit_cout),
        .sum    (bit_sum)
    );

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count_q == LAST) state_next = FIN;
            end
            FIN: begin
                fin        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            count_q <= '0;
            shreg   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b;
            cmd_q   <= command;
            count_q <= '0;
            carry_q <= ctrl.cin0;
        end else if (step) begin
            shreg   <= {bit_res, shreg[WIDTH-1:1]};
            carry_q <= bit_cout;
            count_q <= count_q + 1'b1;
            if (count_q == LAST) begin
                ovf_q  <= carry_q ^ bit_cout;
                sign_q <= bit_sum;
            end
        end
    end

    // SLT reports the overflow-corrected sign of a-b in bit 0.
    always_comb begin
        res_final = shreg;
        if (cmd_q == CMD_SLT) res_final = {{(WIDTH-1){1'b0}}, sign_q ^ ovf_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            done <= fin;
            if (fin) begin
                result   <= res_final;
                zero     <= (res_final == '0);
                carryout <= ctrl.is_arith & carry_q;
                overflow <= ctrl.is_arith & ovf_q;
            end
        end
    end

endmodule
